// File: rtl/and_gate_checker.sv
// -----------------------------------------------------------------------------
// and_gate_checker
//
// Exhaustively exercises a two-input AND gate. On a start request the block
// walks the four input vectors 00, 01, 10, 11, holding each for DWELL cycles,
// and compares the gate's response against A&B in the last cycle of every
// dwell window (earlier cycles are left for the gate to settle). The sweep is
// repeated NUM_PASSES times, mismatches are counted (saturating at 15), and a
// one-cycle done pulse reports the result.
//
// Parameters
//   DWELL        cycles each vector is held (2..255)
//   NUM_PASSES   truth-table sweeps per run (1..15)
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       run request, honoured only while idle
//   i_gate_out    response of the gate under test
//   o_input_a     gate input A (vector bit 1)
//   o_input_b     gate input B (vector bit 0)
//   o_vector_idx  current vector {A, B}
//   o_busy        high while a run is in progress
//   o_done        one-cycle pulse when a run completes
//   o_pass        run result, valid from o_done until the next accepted start
//   o_err_count   mismatch count of the current or last run
//   dbg_state     current FSM state (IDLE=0, APPLY=1, DONE=2)
//
// Handshake: i_start is a level sampled on each rising edge; it is accepted
// only in IDLE, and o_busy rises on the edge that accepts it. o_done is high
// for exactly the one cycle spent in DONE, with o_busy already low, and the
// result in o_pass/o_err_count stays stable until the next accepted start.
// -----------------------------------------------------------------------------
module and_gate_checker #(
  parameter int DWELL      = 10,
  parameter int NUM_PASSES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_gate_out,
  output logic       o_input_a,
  output logic       o_input_b,
  output logic [1:0] o_vector_idx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_err_count,
  output logic [1:0] dbg_state
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Terminal counts, truncated to the counter widths. The legal parameter
  // ranges guarantee the truncation is lossless.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] PASS_LAST  = 4'(NUM_PASSES - 1);
  localparam logic [3:0] ERR_MAX    = 4'd15;
  localparam logic [1:0] VEC_LAST   = 2'd3;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [7:0] dwell_q;
  logic [3:0] pass_cnt_q;
  logic [1:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;

  // Next-state values
  logic [1:0] state_d;
  logic [7:0] dwell_d;
  logic [3:0] pass_cnt_d;
  logic [1:0] vec_d;
  logic       busy_d;
  logic       done_d;
  logic       pass_d;
  logic [3:0] err_d;

  // ---------------------------------------------------------------------------
  // Compare path
  // ---------------------------------------------------------------------------
  logic       sample_now;  // last cycle of the dwell window
  logic       expected;    // ideal AND response for the vector on the pins
  logic       mismatch;
  logic [3:0] err_upd;     // error count including this cycle's sample

  assign sample_now = (state_q == ST_APPLY) && (dwell_q == DWELL_LAST);
  assign expected   = vec_q[1] & vec_q[0];
  assign mismatch   = sample_now && (i_gate_out != expected);

  // Saturate rather than wrap so a badly broken gate never reads as passing.
  always_comb begin
    err_upd = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_upd = err_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    pass_cnt_d = pass_cnt_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        vec_d  = 2'd0;
        if (i_start) begin
          // Accepting a run clears the previous result.
          state_d    = ST_APPLY;
          busy_d     = 1'b1;
          vec_d      = 2'd0;
          dwell_d    = 8'd0;
          pass_cnt_d = 4'd0;
          err_d      = 4'd0;
          pass_d     = 1'b0;
        end
      end

      ST_APPLY: begin
        err_d = err_upd;
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          if (vec_q == VEC_LAST) begin
            vec_d = 2'd0;
            if (pass_cnt_q == PASS_LAST) begin
              // The verdict must include the sample taken on this very edge,
              // hence err_upd rather than the registered count.
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_upd == 4'd0);
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end

      ST_DONE: begin
        // Single-cycle report state; i_start is not looked at here so a held
        // start can only launch a new run from IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        vec_d   = 2'd0;
      end

      default: begin
        state_d    = ST_IDLE;
        dwell_d    = 8'd0;
        pass_cnt_d = 4'd0;
        vec_d      = 2'd0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      dwell_q    <= 8'd0;
      pass_cnt_q <= 4'd0;
      vec_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      pass_cnt_q <= pass_cnt_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: every output is a flop or a plain wire from one.
  // ---------------------------------------------------------------------------
  assign o_input_a    = vec_q[1];
  assign o_input_b    = vec_q[0];
  assign o_vector_idx = vec_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_count  = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_and_gate_checker
//
// Two checker instances share clock and reset:
//   u_a  DWELL=10, NUM_PASSES=1  (40-cycle runs)
//   u_b  DWELL=4,  NUM_PASSES=8  (128-cycle runs)
// Each drives a modelled gate whose behaviour is selected per run (good,
// stuck-at-1, stuck-at-0, NOT-AND). Issuing a run pushes the expected
// {busy cycles, error count, pass} into that instance's queue; a monitor per
// instance pops and compares on every o_done, and checks the vector sequence
// while busy.
// -----------------------------------------------------------------------------
module tb_and_gate_checker;

  localparam int DW_A = 10;
  localparam int NP_A = 1;
  localparam int DW_B = 4;
  localparam int NP_B = 8;
  localparam int W    = 21;  // {busy_cycles[15:0], err[3:0], pass}

  localparam logic [1:0] M_GOOD = 2'd0;
  localparam logic [1:0] M_ST1  = 2'd1;
  localparam logic [1:0] M_ST0  = 2'd2;
  localparam logic [1:0] M_NAND = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic       start_a, gate_a, ina_a, inb_a, busy_a, done_a, pass_a;
  logic [1:0] vec_a, st_a, mode_a;
  logic [3:0] err_a;
  logic       start_b, gate_b, ina_b, inb_b, busy_b, done_b, pass_b;
  logic [1:0] vec_b, st_b, mode_b;
  logic [3:0] err_b;

  function automatic logic gate_fn(input logic [1:0] m, input logic a,
                                   input logic b);
    case (m)
      M_GOOD:  gate_fn = a & b;
      M_ST1:   gate_fn = 1'b1;
      M_ST0:   gate_fn = 1'b0;
      default: gate_fn = ~(a & b);
    endcase
  endfunction

  assign gate_a = gate_fn(mode_a, ina_a, inb_a);
  assign gate_b = gate_fn(mode_b, ina_b, inb_b);

  and_gate_checker #(.DWELL(DW_A), .NUM_PASSES(NP_A)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_gate_out(gate_a),
    .o_input_a(ina_a), .o_input_b(inb_a), .o_vector_idx(vec_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_count(err_a),
    .dbg_state(st_a)
  );

  and_gate_checker #(.DWELL(DW_B), .NUM_PASSES(NP_B)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_gate_out(gate_b),
    .o_input_a(ina_b), .o_input_b(inb_b), .o_vector_idx(vec_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_count(err_b),
    .dbg_state(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor for u_a
  int run_a = 0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (done_a) begin
        if (exp_q_a.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          e = exp_q_a.pop_front();
          check("a_busy_cycles", run_a, {16'd0, e[20:5]});
          check("a_err_count", {28'd0, err_a}, {28'd0, e[4:1]});
          check("a_pass", {31'd0, pass_a}, {31'd0, e[0]});
          check("a_done_vec", {30'd0, vec_a}, 0);
        end
      end
      if (busy_a) begin
        check("a_vec_order", {30'd0, vec_a}, (run_a / DW_A) % 4);
        check("a_vec_pins", {30'd0, vec_a}, {30'd0, ina_a, inb_a});
        run_a++;
      end else begin
        run_a = 0;
      end
    end else begin
      run_a = 0;
    end
  end

  // Monitor for u_b
  int run_b = 0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (done_b) begin
        if (exp_q_b.size() == 0) begin
          check("b_unexpected_done", 1, 0);
        end else begin
          e = exp_q_b.pop_front();
          check("b_busy_cycles", run_b, {16'd0, e[20:5]});
          check("b_err_count", {28'd0, err_b}, {28'd0, e[4:1]});
          check("b_pass", {31'd0, pass_b}, {31'd0, e[0]});
          check("b_done_vec", {30'd0, vec_b}, 0);
        end
      end
      if (busy_b) begin
        check("b_vec_order", {30'd0, vec_b}, (run_b / DW_B) % 4);
        check("b_vec_pins", {30'd0, vec_b}, {30'd0, ina_b, inb_b});
        run_b++;
      end else begin
        run_b = 0;
      end
    end else begin
      run_b = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic wait_done_a(input int limit);
    int k = 0;
    while (!done_a && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) check("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_b(input int limit);
    int k = 0;
    while (!done_b && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done_b) check("b_done_timeout", 0, 1);
  endtask

  task automatic run_a_task(input logic [1:0] m, input logic [3:0] e_err,
                            input logic e_pass);
    mode_a = m;
    exp_q_a.push_back({16'(4 * DW_A * NP_A), e_err, e_pass});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_on_accept", {31'd0, busy_a}, 1);
    wait_done_a(4 * DW_A * NP_A + 10);
    repeat (3) @(negedge clk);
    check("a_idle_err_hold", {28'd0, err_a}, {28'd0, e_err});
    check("a_idle_pass_hold", {31'd0, pass_a}, {31'd0, e_pass});
    check("a_idle_done_low", {31'd0, done_a}, 0);
  endtask

  task automatic run_b_task(input logic [1:0] m, input logic [3:0] e_err,
                            input logic e_pass);
    mode_b = m;
    exp_q_b.push_back({16'(4 * DW_B * NP_B), e_err, e_pass});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_busy_on_accept", {31'd0, busy_b}, 1);
    wait_done_b(4 * DW_B * NP_B + 10);
    repeat (3) @(negedge clk);
    check("b_idle_err_hold", {28'd0, err_b}, {28'd0, e_err});
    check("b_idle_pass_hold", {31'd0, pass_b}, {31'd0, e_pass});
    check("b_idle_done_low", {31'd0, done_b}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = M_GOOD;
    mode_b  = M_GOOD;

    // Reset state
    #1;
    check("rst_a_outs", {24'd0, ina_a, inb_a, vec_a, busy_a, done_a, pass_a, err_a[0]}, 0);
    check("rst_a_err", {28'd0, err_a}, 0);
    check("rst_a_state", {30'd0, st_a}, 0);
    check("rst_b_outs", {24'd0, ina_b, inb_b, vec_b, busy_b, done_b, pass_b, err_b[0]}, 0);
    check("rst_b_err", {28'd0, err_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Good gate on u_a, with a stray start mid-run and a start held through
    // DONE launching the second run only from IDLE.
    mode_a = M_GOOD;
    exp_q_a.push_back({16'(4 * DW_A), 4'd0, 1'b1});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_first_accept", {31'd0, busy_a}, 1);
    repeat (14) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    exp_q_a.push_back({16'(4 * DW_A), 4'd0, 1'b1});
    start_a = 1'b1;
    wait_done_a(30);
    check("a_done_busy_low", {31'd0, busy_a}, 0);
    check("a_done_state", {30'd0, st_a}, 2);
    @(negedge clk);
    check("a_gap_busy", {31'd0, busy_a}, 0);
    check("a_gap_done", {31'd0, done_a}, 0);
    check("a_gap_pass_hold", {31'd0, pass_a}, 1);
    @(negedge clk);
    check("a_restart_busy", {31'd0, busy_a}, 1);
    start_a = 1'b0;
    wait_done_a(4 * DW_A + 10);
    @(negedge clk);

    // Faulty gates on u_a (three and four mismatches out of four vectors)
    run_a_task(M_ST1, 4'd3, 1'b0);
    run_a_task(M_NAND, 4'd4, 1'b0);

    // Multi-pass runs on u_b
    run_b_task(M_ST0, 4'd8, 1'b0);
    run_b_task(M_NAND, 4'd15, 1'b0);  // 32 mismatches, saturates
    run_b_task(M_GOOD, 4'd0, 1'b1);

    // Reset in the middle of vector 10 aborts the run without a done pulse.
    mode_a  = M_NAND;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!(vec_a == 2'd2) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("a_reached_vec10", {30'd0, vec_a}, 2);
    repeat (3) @(negedge clk);
    check("a_pre_reset_err", {28'd0, err_a}, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_async_vec", {29'd0, ina_a, inb_a, vec_a == 2'd0}, 1);
    check("a_async_busy", {31'd0, busy_a}, 0);
    check("a_async_done", {31'd0, done_a}, 0);
    check("a_async_err", {28'd0, err_a}, 0);
    check("a_async_pass", {31'd0, pass_a}, 0);
    check("a_async_state", {30'd0, st_a}, 0);
    repeat (2) @(negedge clk);
    check("a_rst_no_done", {31'd0, done_a}, 0);
    rst_n = 1'b1;
    // Start on the same negedge as release: accepted on the first edge.
    run_a_task(M_GOOD, 4'd0, 1'b1);

    repeat (3) @(negedge clk);
    check("a_queue_empty", exp_q_a.size(), 0);
    check("b_queue_empty", exp_q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/and_gate_checker.md
AND_GATE_CHECKER -- requirements
Module: and_gate_checker

Interface
REQ-001 The block SHALL have parameter DWELL, default 10, giving the clock cycles each input vector is held (legal range 2..255).
REQ-002 The block SHALL have parameter NUM_PASSES, default 1, giving the full truth-table sweeps per run (legal range 1..15).
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_start  input  1  run request, sampled on rising edge.
REQ-006 i_gate_out  input  1  output of the AND gate under test.
REQ-007 o_input_a  output  1  drives gate input A.
REQ-008 o_input_b  output  1  drives gate input B.
REQ-009 o_vector_idx  output  2  current vector, {o_input_a, o_input_b}.
REQ-010 o_busy  output  1  high while a run is in progress.
REQ-011 o_done  output  1  one-cycle pulse at end of run.
REQ-012 o_pass  output  1  run result, valid from o_done until the next accepted start.
REQ-013 o_err_count  output  4  mismatch count for the current or last run.

Function
REQ-014 The FSM SHALL have the states IDLE, APPLY and DONE.
REQ-015 In IDLE, i_start=1 SHALL cause, on the next edge: APPLY, o_busy=1, vector 00, dwell counter=0, pass counter=0, o_err_count=0, o_pass=0.
REQ-016 i_start SHALL be ignored while in APPLY or DONE.
REQ-017 In APPLY the vector order SHALL be 00, 01, 10, 11, with each vector held for exactly DWELL cycles.
REQ-018 The dwell counter SHALL run 0..DWELL-1 and then wrap to 0 on the vector change.
REQ-019 i_gate_out SHALL be sampled only in the cycle where the dwell counter = DWELL-1, which allows gate settling.
REQ-020 The expected value SHALL be o_input_a AND o_input_b.
REQ-021 On a mismatch, o_err_count SHALL increment on that edge and saturate at 15 with no wrap.
REQ-022 After vector 11 the block SHALL return to vector 00 and increment the pass counter, unless that was the last pass.
REQ-023 After vector 11 of pass NUM_PASSES-1 the FSM SHALL go to DONE.
REQ-024 The block SHALL spend exactly 4*DWELL*NUM_PASSES cycles in APPLY.
REQ-025 In DONE, for one cycle: o_done=1, o_busy=0, o_pass=(o_err_count==0) using the count including the final sample, and vector outputs=00.
REQ-026 After the DONE cycle the FSM SHALL go to IDLE unconditionally.
REQ-027 In IDLE, o_pass and o_err_count SHALL hold their values, o_done=0, o_busy=0, and vector=00.
REQ-028 An i_start held high through DONE SHALL start a new run only from IDLE, i.e. no earlier than the cycle after o_done.
REQ-029 All outputs SHALL be registered, with no combinational path from i_gate_out or i_start to any output.

Reset
REQ-030 i_rst_n=0 SHALL immediately, without waiting for a clock: force IDLE, set o_input_a=o_input_b=0, o_vector_idx=0, o_busy=0, o_done=0, o_pass=0, o_err_count=0, and clear the dwell and pass counters.
REQ-031 A reset asserted mid-run SHALL abort the run with no o_done pulse, and a later i_start SHALL begin a fresh run from vector 00.
REQ-032 Release of i_rst_n SHALL be synchronous to i_clk, and the first i_start SHALL be accepted on the first edge after release.

Verification
REQ-033 Good gate, DWELL=10, NUM_PASSES=1, i_start pulse -> vectors 00,01,10,11 each 10 cycles, o_busy high 40 cycles, o_done pulse, o_pass=1, o_err_count=0.
REQ-034 i_gate_out stuck at 1, DWELL=4 -> three mismatches, o_err_count=3, o_pass=0 at o_done.
REQ-035 i_gate_out stuck at 0, NUM_PASSES=8 -> 8 mismatches (vector 11 each pass), o_err_count=8, o_pass=0, o_busy high 4*DWELL*8 cycles.
REQ-036 Always-wrong gate (NOT AND), NUM_PASSES=5 -> 20 mismatches, o_err_count saturates at 15 and holds.
REQ-037 i_rst_n low during vector 10 -> all outputs 0 asynchronously, no o_done; a new i_start -> clean run with o_err_count reset.
REQ-038 i_start pulsed mid-run and held high through DONE -> the mid-run pulse has no effect, and the second run's o_busy rises on the edge after the o_done cycle.
